// File: rtl/hazard_scoreboard.sv
// Per-register latency scoreboard for an in-order pipeline: tracks outstanding
// producer latencies and stalls decode while a source operand is still in flight.
module hazard_scoreboard #(
  parameter int NREG       = 32,
  parameter int AW         = 5,
  parameter int ALU_STALL  = 0,
  parameter int LOAD_STALL = 1,
  parameter int MUL_STALL  = 3,
  parameter int CW         = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs_addr,
  input  logic [AW-1:0]   rt_addr,
  input  logic            rs_used,
  input  logic            rt_used,
  input  logic            issue_valid,
  input  logic            issue_we,
  input  logic [AW-1:0]   issue_addr,
  input  logic [1:0]      issue_class,
  input  logic            flush,
  output logic            stall,
  output logic [NREG-1:0] busy,
  output logic [31:0]     stall_count
);

  // Handshake: decode offers an instruction with issue_valid; stall acts as the
  // inverse of ready. An instruction is taken only in a cycle where
  // issue_valid=1, stall=0 and flush=0; otherwise decode must hold it.

  logic [CW-1:0] cnt [NREG];
  logic [CW-1:0] cnt_rs;
  logic [CW-1:0] cnt_rt;
  logic [CW-1:0] lat;
  logic          accepted;
  logic          mark;

  always_comb begin
    case (issue_class)
      2'd1:    lat = CW'(LOAD_STALL);
      2'd2:    lat = CW'(MUL_STALL);
      default: lat = CW'(ALU_STALL);
    endcase
  end

  // Register 0 and addresses beyond NREG never match, so they read as idle.
  always_comb begin
    cnt_rs = '0;
    cnt_rt = '0;
    for (int r = 1; r < NREG; r++) begin
      if (rs_addr == AW'(r)) cnt_rs = cnt[r];
      if (rt_addr == AW'(r)) cnt_rt = cnt[r];
    end
  end

  always_comb begin
    stall    = (rs_used & issue_valid & (cnt_rs != '0)) |
               (rt_used & issue_valid & (cnt_rt != '0));
    accepted = issue_valid & ~stall & ~flush;
    mark     = accepted & issue_we & (lat != '0);
  end

  // busy is a pure function of the counter registers.
  always_comb begin
    busy = '0;
    for (int r = 0; r < NREG; r++) begin
      busy[r] = (cnt[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (r == 0 || flush) begin
          cnt[r] <= '0;
        end else if (mark && issue_addr == AW'(r)) begin
          // WAW: keep whichever outstanding latency finishes later.
          if (cnt[r] == '0 || lat > (cnt[r] - CW'(1))) cnt[r] <= lat;
          else                                          cnt[r] <= cnt[r] - CW'(1);
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && stall_count != 32'hFFFF_FFFF) begin
      stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed hazard scenarios plus randomized traffic
// compared against an integer remaining-latency model of the register file.
module tb_hazard_scoreboard;

  localparam int NREG = 24;
  localparam int AW   = 5;

  logic            clk;
  logic            rst_n;
  logic [AW-1:0]   rs_addr, rt_addr, issue_addr;
  logic            rs_used, rt_used, issue_valid, issue_we, flush;
  logic [1:0]      issue_class;
  logic            stall;
  logic [NREG-1:0] busy;
  logic [31:0]     stall_count;

  int n_checks = 0;
  int n_errors = 0;

  int          mcnt [NREG];
  logic [31:0] msc;
  logic        dut_stall;

  hazard_scoreboard #(.NREG(NREG), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used), .rt_used(rt_used),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_addr(issue_addr),
    .issue_class(issue_class), .flush(flush),
    .stall(stall), .busy(busy), .stall_count(stall_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: remaining stall cycles per register as plain integers.
  function automatic int lat_of(input logic [1:0] c);
    case (c)
      2'd1:    return 1;
      2'd2:    return 3;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_pending(input logic [AW-1:0] a);
    int i = int'(a);
    if (i >= NREG) return 1'b0;
    return mcnt[i] > 0;
  endfunction

  function automatic logic [NREG-1:0] model_busy();
    logic [NREG-1:0] b = '0;
    for (int r = 0; r < NREG; r++) b[r] = (mcnt[r] > 0);
    return b;
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < NREG; r++) mcnt[r] = 0;
    msc = 32'd0;
  endfunction

  task automatic set_idle();
    rs_addr = '0; rt_addr = '0; rs_used = 1'b0; rt_used = 1'b0;
    issue_valid = 1'b0; issue_we = 1'b0; issue_addr = '0; issue_class = 2'd0;
    flush = 1'b0;
  endtask

  // Driver: one decode cycle, checked against the model before and after the edge.
  task automatic step(input logic [AW-1:0] rs, input logic rsu,
                      input logic [AW-1:0] rt, input logic rtu,
                      input logic iv, input logic we, input logic [AW-1:0] ia,
                      input logic [1:0] ic, input logic fl);
    bit exp_stall;
    int nxt [NREG];
    int L, d;
    @(negedge clk);
    rs_addr = rs; rs_used = rsu; rt_addr = rt; rt_used = rtu;
    issue_valid = iv; issue_we = we; issue_addr = ia; issue_class = ic; flush = fl;
    #1;
    exp_stall = iv && ((rsu && model_pending(rs)) || (rtu && model_pending(rt)));
    dut_stall = stall;
    check("stall", 64'(stall), 64'(exp_stall));
    check("busy", 64'(busy), 64'(model_busy()));
    @(posedge clk);
    L = lat_of(ic);
    d = int'(ia);
    if (fl) begin
      for (int r = 0; r < NREG; r++) mcnt[r] = 0;
    end else begin
      for (int r = 0; r < NREG; r++) nxt[r] = (mcnt[r] > 0) ? mcnt[r] - 1 : 0;
      if (iv && !exp_stall && we && d != 0 && d < NREG && L > 0)
        nxt[d] = (L > mcnt[d] - 1) ? L : mcnt[d] - 1;
      for (int r = 0; r < NREG; r++) mcnt[r] = nxt[r];
    end
    if (exp_stall && msc != 32'hFFFF_FFFF) msc = msc + 32'd1;
    #1;
    check("stall_count", 64'(stall_count), 64'(msc));
  endtask

  task automatic idle_step();
    step('0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 2'd0, 1'b0);
  endtask

  initial begin
    logic [AW-1:0] ra, rb, da;
    set_idle();
    model_clear();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_stall_count", 64'(stall_count), 64'd0);
    rst_n = 1'b1;

    // Load-use: exactly one stall cycle.
    step('0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 5'd5, 2'd1, 1'b0);
    step(5'd5, 1'b1, '0, 1'b0, 1'b1, 1'b1, 5'd6, 2'd0, 1'b0);
    check("loaduse_stall_c1", 64'(dut_stall), 64'd1);
    step(5'd5, 1'b1, '0, 1'b0, 1'b1, 1'b1, 5'd6, 2'd0, 1'b0);
    check("loaduse_accept_c2", 64'(dut_stall), 64'd0);
    check("loaduse_count", 64'(stall_count), 64'd1);

    // Mul chain: reader on rt stalls three cycles.
    step('0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 5'd7, 2'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step('0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, 5'd8, 2'd0, 1'b0);
      check("mul_stall", 64'(dut_stall), 64'd1);
    end
    check("mul_busy7_clear", 64'(busy[7]), 64'd0);
    step('0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, 5'd8, 2'd0, 1'b0);
    check("mul_accept", 64'(dut_stall), 64'd0);

    // WAW: a later load to r4 keeps the longer mul latency (2 remaining).
    step('0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 5'd4, 2'd2, 1'b0);
    step('0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 5'd4, 2'd1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(5'd4, 1'b1, '0, 1'b0, 1'b1, 1'b0, '0, 2'd0, 1'b0);
      check("waw_stall", 64'(dut_stall), 64'd1);
    end
    step(5'd4, 1'b1, '0, 1'b0, 1'b1, 1'b0, '0, 2'd0, 1'b0);
    check("waw_accept", 64'(dut_stall), 64'd0);

    // Flush discards pending hazards.
    step('0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 5'd9, 2'd1, 1'b0);
    step('0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 5'd10, 2'd2, 1'b0);
    step('0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 2'd0, 1'b1);
    check("flush_busy", 64'(busy), 64'd0);
    step(5'd10, 1'b1, '0, 1'b0, 1'b1, 1'b0, '0, 2'd0, 1'b0);
    check("flush_reader", 64'(dut_stall), 64'd0);

    // Register 0 and an out-of-range register are never tracked.
    step('0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 5'd0, 2'd1, 1'b0);
    check("r0_busy", 64'(busy), 64'd0);
    step(5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, '0, 2'd0, 1'b0);
    check("r0_stall", 64'(dut_stall), 64'd0);
    step('0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 5'd30, 2'd2, 1'b0);
    check("oor_busy", 64'(busy), 64'd0);
    step(5'd30, 1'b1, 5'd30, 1'b1, 1'b1, 1'b0, '0, 2'd0, 1'b0);
    check("oor_stall", 64'(dut_stall), 64'd0);

    // Async reset mid-countdown, pulsed between edges.
    step('0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 5'd3, 2'd2, 1'b0);
    step(5'd3, 1'b1, '0, 1'b0, 1'b1, 1'b0, '0, 2'd0, 1'b0);
    set_idle();
    @(negedge clk);
    #1;
    check("pre_rst_busy3", 64'(busy[3]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_count", 64'(stall_count), 64'd0);
    rst_n = 1'b1;
    model_clear();
    step('0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, '0, 2'd0, 1'b0);
    check("post_rst_no_stall", 64'(dut_stall), 64'd0);

    // Randomized traffic, biased toward a few registers to create hazards.
    for (int i = 0; i < 2500; i++) begin
      ra = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 6));
      rb = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 6));
      da = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 6));
      step(ra, 1'($urandom_range(0, 1)), rb, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) != 0), da,
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 39) == 0));
    end
    idle_step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32: architectural register count; register 0 is hardwired zero.
REQ-002 SHALL have parameter AW, default 5: register address width, with NREG <= 2^AW.
REQ-003 SHALL have parameter ALU_STALL, default 0: stall cycles owed to a dependent of an ALU-class producer.
REQ-004 SHALL have parameter LOAD_STALL, default 1: stall cycles owed to a dependent of a load-class producer.
REQ-005 SHALL have parameter MUL_STALL, default 3: stall cycles owed to a dependent of a mul/div-class producer.
REQ-006 SHALL have parameter CW, default 3: per-register countdown width; every *_STALL value SHALL be <= 2^CW-1.
REQ-007 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-008 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-009 SHALL have port rs_addr, input, AW: source register A of the instruction in decode.
REQ-010 SHALL have port rt_addr, input, AW: source register B of the instruction in decode.
REQ-011 SHALL have port rs_used, input, 1: decode reads rs.
REQ-012 SHALL have port rt_used, input, 1: decode reads rt.
REQ-013 SHALL have port issue_valid, input, 1: decode presents an instruction this cycle.
REQ-014 SHALL have port issue_we, input, 1: the presented instruction writes a register.
REQ-015 SHALL have port issue_addr, input, AW: destination register of the presented instruction.
REQ-016 SHALL have port issue_class, input, 2: producer class; 0 = ALU, 1 = load, 2 = mul/div, 3 = treated as ALU.
REQ-017 SHALL have port flush, input, 1: pipeline flush, e.g. on a taken branch squash.
REQ-018 SHALL have port stall, output, 1: hold decode this cycle.
REQ-019 SHALL have port busy, output, NREG: bit r is set while counter r is nonzero.
REQ-020 SHALL have port stall_count, output, 32: saturating count of stalled cycles.

Function
REQ-021 SHALL keep one CW-bit countdown cnt[r] per register r; cnt[0] SHALL be constant 0.
REQ-022 SHALL drive stall combinationally as (rs_used & issue_valid & cnt[rs_addr]!=0) | (rt_used & issue_valid & cnt[rt_addr]!=0).
REQ-023 SHALL define an issue as accepted when issue_valid=1, stall=0 and flush=0.
REQ-024 SHALL define a marking issue as an accepted issue with issue_we=1, issue_addr!=0 and class latency L>0, where L is ALU_STALL, LOAD_STALL or MUL_STALL according to issue_class.
REQ-025 SHALL decrement every nonzero cnt[r] by 1 per cycle, unless flush is asserted or r is marked in that cycle.
REQ-026 On a marking issue to register d, SHALL load cnt[d] <= max(L, cnt[d]-1) (WAW: the longer outstanding latency wins); if cnt[d] was 0, load L.
REQ-027 An accepted issue with L=0, issue_we=0 or issue_addr=0 SHALL leave cnt unchanged apart from the normal decrement.
REQ-028 With flush=1, SHALL clear all counters at the next edge; flush SHALL take priority over both issue and decrement.
REQ-029 A stalled instruction SHALL not mark its destination.
REQ-030 A dependent instruction SHALL stall for exactly L cycles when it enters decode the cycle after its producer issues.
REQ-031 SHALL increment stall_count on each edge where stall=1; at 32'hFFFFFFFF it SHALL hold.
REQ-032 SHALL never assert stall for register 0, even if rs_used or rt_used is set.
REQ-033 Out-of-range addresses (>= NREG) SHALL read as not busy and SHALL not be marked.
REQ-034 busy SHALL be registered state only, with no combinational path from the issue inputs.

Reset
REQ-035 While rst_n=0, SHALL immediately clear all cnt, busy and stall_count, regardless of clk.
REQ-036 After rst_n deasserts, the first edge SHALL behave as a normal cycle with all registers idle.
REQ-037 Reset asserted mid-countdown SHALL discard all pending hazards, so no stall follows reset release.

Verification
REQ-038 Load-use: load r5 issues at cycle 0; at cycle 1, add using rs=r5 -> stall=1 in cycle 1 only; add accepted in cycle 2; stall_count=1.
REQ-039 Mul chain: mul r7 issues; dependent reads rt=r7 next cycle -> stall for 3 cycles; busy[7] clears after 3 edges.
REQ-040 WAW: mul r4 (cnt=3); next cycle load r4 -> cnt[4]=max(1,2)=2; a reader of r4 stalls 2 cycles.
REQ-041 Flush: load r9 then mul r10; flush=1 for one cycle -> busy=0 next cycle; reader of r10 is not stalled.
REQ-042 Zero register: load r0, then a reader with rs=r0 -> stall=0 and busy=0 throughout.
REQ-043 Async reset: with busy[3]=1, pulse rst_n low between clock edges -> busy and stall_count read 0 before the next edge.
